uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter giving NUM_REQ requesters turns on one uart_tx.
// A character is loaded into the transmitter one cycle after the request is seen.
// The arbiter then waits for the frame to start (tx_empty falls) and to finish
// (tx_empty rises) before it grants again.
// Optional feature: define UART_ARB_TIMEOUT_EN to add a watchdog in WAIT_START
// that aborts a load the transmitter never starts and pulses timeout_err.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned DATA_LEN       = 8,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*DATA_LEN-1:0]  req_data,
    output logic [NUM_REQ-1:0]           req_ack,
    output logic [NUM_REQ-1:0]           grant,
    output logic [DATA_LEN-1:0]          tx_data,
    output logic                         tx_load,
    input  logic                         tx_empty,
    output logic                         busy,
    output logic                         timeout_err
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Elaboration-time parameter sanity checks
    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("uart_tx_arbiter: NUM_REQ must be 2..8");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("uart_tx_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        LOAD       = 2'd1,
        WAIT_START = 2'd2,
        WAIT_DONE  = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [IDX_W-1:0]     win_q, win_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [NUM_REQ-1:0]   req_ack_q, req_ack_d;
    logic [DATA_LEN-1:0]  tx_data_q, tx_data_d;
    logic                 tx_load_q, tx_load_d;
    logic                 busy_q, busy_d;

    logic                 win_found;
    logic [IDX_W-1:0]     win_idx;
    logic [NUM_REQ-1:0]   win_onehot;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 timeout_err_q, timeout_err_d;
`endif

    // Round-robin search starting one past the last served requester
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            if (!win_found && req[IDX_W'((32'(ptr_q) + k) % NUM_REQ)]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'((32'(ptr_q) + k) % NUM_REQ);
            end
        end
        win_onehot = NUM_REQ'(1) << win_idx;
    end

    // Next-state and registered-output computation
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        win_d     = win_q;
        grant_d   = grant_q;
        tx_data_d = tx_data_q;
        req_ack_d = '0;
        tx_load_d = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
        cnt_d         = '0;
        timeout_err_d = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                // Only grant when the transmitter is free; winner's data is captured now
                if (tx_empty && win_found) begin
                    state_d   = LOAD;
                    win_d     = win_idx;
                    grant_d   = win_onehot;
                    tx_data_d = req_data[32'(win_idx) * DATA_LEN +: DATA_LEN];
                    tx_load_d = 1'b1;
                    req_ack_d = win_onehot;
                end
            end
            LOAD: begin
                state_d = WAIT_START;
            end
            WAIT_START: begin
                if (!tx_empty) begin
                    state_d = WAIT_DONE;
                end
`ifdef UART_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    // Transmitter never took the character: abandon it and move on
                    state_d       = IDLE;
                    grant_d       = '0;
                    ptr_d         = win_q;
                    timeout_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            WAIT_DONE: begin
                if (tx_empty) begin
                    state_d = IDLE;
                    grant_d = '0;
                    ptr_d   = win_q;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            ptr_q     <= IDX_W'(NUM_REQ - 1);
            win_q     <= '0;
            grant_q   <= '0;
            req_ack_q <= '0;
            tx_data_q <= '0;
            tx_load_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            win_q     <= win_d;
            grant_q   <= grant_d;
            req_ack_q <= req_ack_d;
            tx_data_q <= tx_data_d;
            tx_load_q <= tx_load_d;
            busy_q    <= busy_d;
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    // Watchdog counter and error pulse registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign req_ack = req_ack_q;
    assign grant   = grant_q;
    assign tx_data = tx_data_q;
    assign tx_load = tx_load_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: expected grants are queued by the stimulus
// thread and matched by a monitor whenever tx_load is presented.
module tb_uart_tx_arbiter;

    localparam int unsigned NUM_REQ  = 4;
    localparam int unsigned DATA_LEN = 8;

    logic                        clk = 1'b0;
    logic                        rst = 1'b0;
    logic [NUM_REQ-1:0]          req = '0;
    logic [NUM_REQ*DATA_LEN-1:0] req_data = '0;
    logic [NUM_REQ-1:0]          req_ack;
    logic [NUM_REQ-1:0]          grant;
    logic [DATA_LEN-1:0]         tx_data;
    logic                        tx_load;
    logic                        tx_empty = 1'b1;
    logic                        busy;
    logic                        timeout_err;

    typedef struct {
        int          idx;
        logic [7:0]  data;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    uart_tx_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .DATA_LEN       (DATA_LEN),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_data    (req_data),
        .req_ack     (req_ack),
        .grant       (grant),
        .tx_data     (tx_data),
        .tx_load     (tx_load),
        .tx_empty    (tx_empty),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic set_data(input int i, input logic [7:0] d);
        req_data[i*8 +: 8] = d;
    endtask

    task automatic push_exp(input int i, input logic [7:0] d);
        exp_t e;
        e.idx  = i;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_grant"},   32'(grant),       32'd0);
        chk({tag, "_req_ack"}, 32'(req_ack),     32'd0);
        chk({tag, "_tx_load"}, 32'(tx_load),     32'd0);
        chk({tag, "_tx_data"}, 32'(tx_data),     32'd0);
        chk({tag, "_busy"},    32'(busy),        32'd0);
        chk({tag, "_tmo_err"}, 32'(timeout_err), 32'd0);
    endtask

    // Bounded wait; returns on the negedge where tx_load is seen
    task automatic wait_load();
        bit seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            if (tx_load) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL wait_load: tx_load got 0 expected 1 within 40 cycles");
        end
    endtask

    // Transmitter model: take the load, go busy for frame_len cycles, return idle
    task automatic serve_frame(input logic [NUM_REQ-1:0] drop, input int frame_len);
        wait_load();
        req = req & ~drop;
        @(negedge clk);
        tx_empty = 1'b0;
        repeat (frame_len) @(negedge clk);
        tx_empty = 1'b1;
    endtask

    // Monitor: compare every presented load against the scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst && tx_load) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_load: grant got %0h expected no load", grant);
                end else begin
                    e = exp_q.pop_front();
                    chk("mon_grant",   32'(grant),   32'(4'b0001 << e.idx));
                    chk("mon_req_ack", 32'(req_ack), 32'(4'b0001 << e.idx));
                    chk("mon_tx_data", 32'(tx_data), 32'(e.data));
                    chk("mon_busy",    32'(busy),    32'd1);
                end
            end else if (rst) begin
                chk("mon_ack_without_load", 32'(req_ack), 32'd0);
            end
        end
    end

    // Global time bound
    initial begin
        #500000;
        $display("FAIL global_timeout: simulation got stuck expected completion");
        $fatal(1, "global timeout");
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;
        @(negedge clk);

        // Single requester 0 with 0xA5
        set_data(0, 8'hA5);
        push_exp(0, 8'hA5);
        req = 4'b0001;
        serve_frame(4'b0001, 4);
        repeat (3) @(negedge clk);

        // Reset in IDLE so the pointer restarts at index 0
        #2 rst = 1'b0;
        #1 check_all_zero("reset_idle");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // All four requesting continuously: 0,1,2,3,0
        for (int i = 0; i < 4; i++) set_data(i, 8'(8'h10 + i));
        push_exp(0, 8'h10);
        push_exp(1, 8'h11);
        push_exp(2, 8'h12);
        push_exp(3, 8'h13);
        push_exp(0, 8'h10);
        req = 4'b1111;
        for (int i = 0; i < 4; i++) serve_frame(4'b0000, 3);
        serve_frame(4'b1111, 3);
        repeat (3) @(negedge clk);

        // Requester 2 arrives while requester 0's frame is in WAIT_DONE
        set_data(0, 8'h3C);
        set_data(2, 8'hC3);
        push_exp(0, 8'h3C);
        push_exp(2, 8'hC3);
        req = 4'b0001;
        wait_load();
        req = 4'b0000;
        @(negedge clk);
        tx_empty = 1'b0;
        repeat (2) @(negedge clk);
        req = 4'b0100;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("late_req_no_load", 32'(tx_load), 32'd0);
            chk("late_req_grant",   32'(grant),   32'b0001);
        end
        tx_empty = 1'b1;
        serve_frame(4'b0100, 4);
        repeat (3) @(negedge clk);

        // Transmitter busy in IDLE: nothing may be granted
        tx_empty = 1'b0;
        set_data(1, 8'h5A);
        req = 4'b0010;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("ext_busy_no_load", 32'(tx_load), 32'd0);
            chk("ext_busy_grant",   32'(grant),   32'd0);
        end
        push_exp(1, 8'h5A);
        tx_empty = 1'b1;
        serve_frame(4'b0010, 3);
        repeat (3) @(negedge clk);

        // Reset mid-frame, then lowest requesting index wins after release
        set_data(3, 8'h96);
        push_exp(3, 8'h96);
        req = 4'b1000;
        wait_load();
        req = 4'b0000;
        @(negedge clk);
        tx_empty = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1 check_all_zero("reset_mid_frame");
        @(negedge clk);
        set_data(1, 8'h11);
        set_data(2, 8'h22);
        req = 4'b0110;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_reset_no_load", 32'(tx_load), 32'd0);
            chk("post_reset_grant",   32'(grant),   32'd0);
        end
        push_exp(1, 8'h11);
        push_exp(2, 8'h22);
        tx_empty = 1'b1;
        serve_frame(4'b0010, 3);
        serve_frame(4'b0100, 3);
        repeat (3) @(negedge clk);

`ifdef UART_ARB_TIMEOUT_EN
        // Transmitter never starts: watchdog fires, next requester served
        begin
            bit early = 1'b0;
            set_data(0, 8'h77);
            set_data(1, 8'h88);
            push_exp(0, 8'h77);
            push_exp(1, 8'h88);
            req = 4'b0011;
            wait_load();
            req = 4'b0010;
            for (int i = 1; i <= 16; i++) begin
                @(negedge clk);
                if (timeout_err) early = 1'b1;
            end
            chk("timeout_not_early", 32'(early), 32'd0);
            @(negedge clk);
            chk("timeout_pulse", 32'(timeout_err), 32'd1);
            chk("timeout_busy",  32'(busy),        32'd0);
            chk("timeout_grant", 32'(grant),       32'd0);
            serve_frame(4'b0010, 3);
            chk("timeout_pulse_end", 32'(timeout_err), 32'd0);
            repeat (3) @(negedge clk);
        end
`endif

        repeat (10) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
